set_mode_ctrl: RTL and testbench
================================

SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 500: tick_1k pulses per BLINK half-period.
REQ-002 SHALL have parameter TIMEOUT, default 10000: idle tick_1k pulses before a set or ring state exits to NORMAL.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port tick_1k, input, 1: one-cycle 1 kHz strobe.
REQ-006 SHALL have ports btn_mode, btn_next and btn_inc, input, 1 each: synchronized, debounced button levels.
REQ-007 SHALL have port alarm_match, input, 1: current time equals alarm time.
REQ-008 SHALL have port S, output, 2: mode; 00 NORMAL, 01 RING, 10 SET_ALARM, 11 SET_TIME.
REQ-009 SHALL have port CW, output, 2: time-set cursor, digit 0..3.
REQ-010 SHALL have port CW1, output, 2: alarm-set cursor, digit 0..3.
REQ-011 SHALL have port BLINK, output, 1: blink phase; 1 means digit visible.
REQ-012 SHALL have port inc_pulse, output, 1: one-cycle request to increment the selected digit.
REQ-013 SHALL have port inc_sel, output, 2: digit index for inc_pulse.
REQ-014 SHALL have port inc_tgt, output, 1: target for inc_pulse; 0 time, 1 alarm.
REQ-015 SHALL have port ring, output, 1: buzzer enable.

Function
REQ-016 A button event SHALL be a rising edge: level 1 now, 0 on the previous cycle. A held button SHALL produce exactly one event.
REQ-017 When events coincide in one cycle, only the highest-priority one SHALL be acted on: mode > next > inc. Lower-priority events in that cycle SHALL be dropped.
REQ-018 NORMAL: mode event -> SET_TIME with CW=0. Otherwise alarm_match=1 -> RING. next and inc events SHALL be ignored.
REQ-019 SET_TIME: mode event -> SET_ALARM with CW1=0.
REQ-020 SET_TIME: next event -> CW=CW+1 mod 4 (3 wraps to 0).
REQ-021 SET_TIME: inc event -> inc_pulse=1 on the following cycle, with inc_sel=CW and inc_tgt=0.
REQ-022 SET_ALARM: mode event -> NORMAL.
REQ-023 SET_ALARM: next event -> CW1=CW1+1 mod 4 (3 wraps to 0).
REQ-024 SET_ALARM: inc event -> inc_pulse=1 on the following cycle, with inc_sel=CW1 and inc_tgt=1.
REQ-025 RING: ring=1. Any button event -> NORMAL, and that event SHALL cause no other action.
REQ-026 alarm_match SHALL be ignored in every state except NORMAL.
REQ-027 Idle counter: increments on tick_1k in SET_TIME, SET_ALARM and RING; clears on any button event and on every state change. Reaching TIMEOUT -> NORMAL on the next edge.
REQ-028 Idle counter SHALL saturate and never wrap.
REQ-029 BLINK SHALL be 1 whenever S is NORMAL or RING.
REQ-030 In SET_TIME and SET_ALARM, BLINK SHALL toggle after each BLINK_HALF tick_1k pulses.
REQ-031 The blink counter SHALL clear and BLINK SHALL be forced to 1 on entry to a set state and on any next or inc event, so the edited digit shows immediately.
REQ-032 On leaving a set state, CW and CW1 SHALL hold their values; they are reloaded to 0 only on entry per REQ-018 and REQ-019.
REQ-033 inc_pulse SHALL never be high two cycles in a row. inc_sel and inc_tgt SHALL be 0 when inc_pulse=0.
REQ-034 All outputs SHALL be registered.
REQ-035 Counter widths SHALL be clog2(parameter+1). A tick_1k arriving in the same cycle as a clearing event SHALL be discarded.

Reset
REQ-036 rst=1 at a clk edge SHALL force: S=00, CW=0, CW1=0, BLINK=1, inc_pulse=0, inc_sel=0, inc_tgt=0, ring=0, all counters 0, button history regs 0.
REQ-037 Reset SHALL take priority over every event, including mid-operation; a button held through reset release SHALL not generate an event.

Structure
REQ-038 State encodings (ST_NORMAL, ST_RING, ST_SET_ALARM, ST_SET_TIME) and the cursor width SHALL live in the shared clock package, so display-side decoders share them.
REQ-039 One sub-module btn_edge (1-bit rising-edge detector with sync reset) SHALL be instantiated three times. The FSM and counters stay in set_mode_ctrl.

Verification (BLINK_HALF=4, TIMEOUT=20)
REQ-040 Scenario: reset, then btn_mode pulse -> S=11, CW=0, BLINK=1; after 4 ticks BLINK=0, after 8 ticks BLINK=1.
REQ-041 Scenario: in SET_TIME, 5 btn_next presses -> CW sequence 1,2,3,0,1. Then btn_inc -> one inc_pulse with inc_sel=1, inc_tgt=0.
REQ-042 Scenario: btn_mode and btn_next rise in the same cycle in SET_TIME -> S=10, CW1=0, CW unchanged.
REQ-043 Scenario: NORMAL with alarm_match=1 -> S=01, ring=1. btn_inc press -> S=00, ring=0, no inc_pulse.
REQ-044 Scenario: SET_ALARM idle 20 ticks -> S=00. A press at tick 19 restarts the count, so exit occurs 20 ticks after that press.
REQ-045 Scenario: assert rst mid-SET_ALARM with btn_next held -> all outputs at reset values; no CW1 change after release.

Source files
------------

// File: rtl/set_mode_ctrl_pkg.sv
// Shared clock-controller definitions: mode encodings and cursor type, used by
// the mode controller and by display-side decoders.
package set_mode_ctrl_pkg;

  localparam int CUR_W = 2;
  typedef logic [CUR_W-1:0] cursor_t;

  localparam logic [1:0] ST_NORMAL    = 2'b00;
  localparam logic [1:0] ST_RING      = 2'b01;
  localparam logic [1:0] ST_SET_ALARM = 2'b10;
  localparam logic [1:0] ST_SET_TIME  = 2'b11;

  function automatic logic is_set_state(input logic [1:0] st);
    return (st == ST_SET_TIME) || (st == ST_SET_ALARM);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level. The edge output stays
// quiet for the first cycle after reset so a button held through reset is not seen.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_btn & ~r_prev & r_armed;

endmodule

// File: rtl/set_mode_ctrl.sv
// Alarm-clock mode controller: NORMAL / RING / SET_ALARM / SET_TIME sequencing,
// digit cursors, edit blink, increment requests and idle timeout.
module set_mode_ctrl
  import set_mode_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 500,
  parameter int TIMEOUT    = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1k,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       alarm_match,
  output logic [1:0] S,
  output cursor_t    CW,
  output cursor_t    CW1,
  output logic       BLINK,
  output logic       inc_pulse,
  output cursor_t    inc_sel,
  output logic       inc_tgt,
  output logic       ring
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT);

  logic w_ev_mode, w_ev_next, w_ev_inc, w_any_ev;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .i_btn(btn_mode), .o_rise(w_ev_mode));
  btn_edge u_edge_next (.clk(clk), .rst(rst), .i_btn(btn_next), .o_rise(w_ev_next));
  btn_edge u_edge_inc  (.clk(clk), .rst(rst), .i_btn(btn_inc),  .o_rise(w_ev_inc));

  assign w_any_ev = w_ev_mode | w_ev_next | w_ev_inc;

  logic [1:0]    r_state;
  cursor_t       r_cw, r_cw1, r_inc_sel;
  logic          r_blink, r_inc_pulse, r_inc_tgt, r_ring;
  logic [BW-1:0] r_blink_cnt;
  logic [IW-1:0] r_idle;

  logic [1:0] w_state_n;
  cursor_t    w_cw_n, w_cw1_n, w_sel_n;
  logic       w_pulse_n, w_tgt_n, w_edit, w_timeout, w_change;

  assign w_timeout = (r_idle == IDLE_MAX);
  assign w_change  = (w_state_n != r_state);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_n = r_state;
    w_cw_n    = r_cw;
    w_cw1_n   = r_cw1;
    w_pulse_n = 1'b0;
    w_sel_n   = '0;
    w_tgt_n   = 1'b0;
    w_edit    = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_ev_mode) begin
          w_state_n = ST_SET_TIME;
          w_cw_n    = '0;
        end else if (alarm_match) begin
          w_state_n = ST_RING;
        end
      end
      ST_SET_TIME: begin
        if (w_ev_mode) begin
          w_state_n = ST_SET_ALARM;
          w_cw1_n   = '0;
        end else if (w_ev_next) begin
          w_cw_n = r_cw + 2'd1;
          w_edit = 1'b1;
        end else if (w_ev_inc) begin
          w_pulse_n = 1'b1;
          w_sel_n   = r_cw;
          w_edit    = 1'b1;
        end else if (w_timeout) begin
          w_state_n = ST_NORMAL;
        end
      end
      ST_SET_ALARM: begin
        if (w_ev_mode) begin
          w_state_n = ST_NORMAL;
        end else if (w_ev_next) begin
          w_cw1_n = r_cw1 + 2'd1;
          w_edit  = 1'b1;
        end else if (w_ev_inc) begin
          w_pulse_n = 1'b1;
          w_sel_n   = r_cw1;
          w_tgt_n   = 1'b1;
          w_edit    = 1'b1;
        end else if (w_timeout) begin
          w_state_n = ST_NORMAL;
        end
      end
      ST_RING: begin
        // Any press only silences the buzzer; it carries no other meaning here.
        if (w_any_ev || w_timeout) w_state_n = ST_NORMAL;
      end
      default: w_state_n = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_NORMAL;
      r_cw        <= '0;
      r_cw1       <= '0;
      r_blink     <= 1'b1;
      r_inc_pulse <= 1'b0;
      r_inc_sel   <= '0;
      r_inc_tgt   <= 1'b0;
      r_ring      <= 1'b0;
      r_blink_cnt <= '0;
      r_idle      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cw        <= w_cw_n;
      r_cw1       <= w_cw1_n;
      r_inc_pulse <= w_pulse_n;
      r_inc_sel   <= w_sel_n;
      r_inc_tgt   <= w_tgt_n;
      r_ring      <= (w_state_n == ST_RING);

      // A tick coinciding with a clearing event is deliberately lost.
      if (w_change || w_any_ev) begin
        r_idle <= '0;
      end else if (tick_1k && r_state != ST_NORMAL && !w_timeout) begin
        r_idle <= r_idle + 1'b1;
      end

      if (!is_set_state(w_state_n) || w_change || w_edit) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b1;
      end else if (tick_1k) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign S         = r_state;
  assign CW        = r_cw;
  assign CW1       = r_cw1;
  assign BLINK     = r_blink;
  assign inc_pulse = r_inc_pulse;
  assign inc_sel   = r_inc_sel;
  assign inc_tgt   = r_inc_tgt;
  assign ring      = r_ring;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Self-checking bench for set_mode_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized stimulus against a behavioural model.
module tb_set_mode_ctrl;

  localparam int BH = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst, tick_1k, btn_mode, btn_next, btn_inc, alarm_match;
  logic [1:0] S, CW, CW1, inc_sel;
  logic       BLINK, inc_pulse, inc_tgt, ring;

  set_mode_ctrl #(.BLINK_HALF(BH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .tick_1k(tick_1k), .btn_mode(btn_mode),
    .btn_next(btn_next), .btn_inc(btn_inc), .alarm_match(alarm_match),
    .S(S), .CW(CW), .CW1(CW1), .BLINK(BLINK), .inc_pulse(inc_pulse),
    .inc_sel(inc_sel), .inc_tgt(inc_tgt), .ring(ring)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        rst, tick, bm, bn, bi, am;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input logic [1:0] s, cw, cw1, input logic bl, p,
                                     input logic [1:0] sel, input logic tgt, rg);
    return {s, cw, cw1, bl, p, sel, tgt, rg};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {S, CW, CW1, BLINK, inc_pulse, inc_sel, inc_tgt, ring};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h  {S,CW,CW1,BLINK,pulse,sel,tgt,ring}",
                  name, act, exp);
  endtask

  task automatic apply(input logic r, t, m, n, i, a);
    rst = r; tick_1k = t; btn_mode = m; btn_next = n; btn_inc = i; alarm_match = a;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, t, m, n, i, a, input logic [1:0] s, cw, cw1,
                     input logic bl, p, input logic [1:0] sel, input logic tgt, rg);
    vec_t v;
    v.rst = r; v.tick = t; v.bm = m; v.bn = n; v.bi = i; v.am = a;
    v.exp = pk(s, cw, cw1, bl, p, sel, tgt, rg);
    vecs.push_back(v);
  endtask

  // Behavioural model: plain integer bookkeeping of mode, cursors, ticks since
  // the last idle/blink restart; blink phase derived by division.
  int m_s, m_cw, m_cw1, m_idle, m_bt, m_since;
  bit m_pm, m_pn, m_pi, m_p, m_tgt;
  int m_sel;

  task automatic m_step(input bit r, t, bm, bn, bi, am);
    bit em, en, ei, edit;
    int old;
    if (r) begin
      m_s = 0; m_cw = 0; m_cw1 = 0; m_idle = 0; m_bt = 0; m_since = 0;
      m_pm = 0; m_pn = 0; m_pi = 0; m_p = 0; m_sel = 0; m_tgt = 0;
      return;
    end
    em = bm && !m_pm && m_since > 0;
    en = bn && !m_pn && m_since > 0;
    ei = bi && !m_pi && m_since > 0;
    m_pm = bm; m_pn = bn; m_pi = bi;
    if (m_since < 2) m_since++;
    old = m_s; edit = 0; m_p = 0; m_sel = 0; m_tgt = 0;
    if (m_s == 0) begin
      if (em) begin m_s = 3; m_cw = 0; end
      else if (am) m_s = 1;
    end else if (m_s == 1) begin
      if (em || en || ei || m_idle >= TO) m_s = 0;
    end else begin
      if (em) begin
        if (m_s == 3) begin m_s = 2; m_cw1 = 0; end
        else m_s = 0;
      end else if (en) begin
        edit = 1;
        if (m_s == 3) m_cw = (m_cw + 1) % 4;
        else m_cw1 = (m_cw1 + 1) % 4;
      end else if (ei) begin
        edit = 1; m_p = 1;
        m_sel = (m_s == 3) ? m_cw : m_cw1;
        m_tgt = (m_s == 2);
      end else if (m_idle >= TO) begin
        m_s = 0;
      end
    end
    if (m_s != old || em || en || ei) m_idle = 0;
    else if (t && m_s != 0) m_idle = (m_idle + 1 > TO) ? TO : m_idle + 1;
    if (m_s < 2 || m_s != old || edit) m_bt = 0;
    else if (t) m_bt++;
  endtask

  function automatic logic [11:0] m_exp();
    logic bl;
    bl = (m_s < 2) ? 1'b1 : (((m_bt / BH) % 2) == 0);
    return pk(2'(m_s), 2'(m_cw), 2'(m_cw1), bl, m_p, 2'(m_sel), m_tgt, m_s == 1);
  endfunction

  initial begin
    rst = 1'b1; tick_1k = 0; btn_mode = 0; btn_next = 0; btn_inc = 0; alarm_match = 0;

    // ---------------- directed vector table ----------------
    //  rst t m n i a    S  CW CW1 BL P SEL T R
    add(1, 0,0,0,0,0,   0, 0, 0,  1, 0, 0, 0, 0);  // reset state
    add(0, 0,0,0,0,0,   0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0,1,0,0,0,   3, 0, 0,  1, 0, 0, 0, 0);  // mode -> SET_TIME
    add(0, 0,0,0,0,0,   3, 0, 0,  1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin             // next x5: 1,2,3,0,1
      add(0, 0,0,1,0,0, 3, 2'(k % 4), 0, 1, 0, 0, 0, 0);
      add(0, 0,0,0,0,0, 3, 2'(k % 4), 0, 1, 0, 0, 0, 0);
    end
    add(0, 0,0,0,1,0,   3, 1, 0,  1, 1, 1, 0, 0);  // inc -> pulse sel=1 tgt=0
    add(0, 0,0,0,1,0,   3, 1, 0,  1, 0, 0, 0, 0);  // held: no second pulse
    add(0, 0,0,0,0,0,   3, 1, 0,  1, 0, 0, 0, 0);
    add(0, 0,1,1,0,0,   2, 1, 0,  1, 0, 0, 0, 0);  // mode+next: mode wins
    add(0, 0,0,0,0,0,   2, 1, 0,  1, 0, 0, 0, 0);
    add(0, 0,0,1,0,0,   2, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0,0,0,0,0,   2, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0,0,0,1,0,   2, 1, 1,  1, 1, 1, 1, 0);  // alarm-digit inc
    add(0, 0,0,0,0,0,   2, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0,1,0,0,0,   0, 1, 1,  1, 0, 0, 0, 0);  // -> NORMAL, cursors hold
    add(0, 0,0,0,0,1,   1, 1, 1,  1, 0, 0, 0, 1);  // alarm_match -> RING
    add(0, 0,0,0,1,1,   0, 1, 1,  1, 0, 0, 0, 0);  // inc silences, no pulse
    add(0, 0,0,0,0,0,   0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0,0,1,0,0,   0, 1, 1,  1, 0, 0, 0, 0);  // next ignored in NORMAL
    add(0, 0,0,0,0,0,   0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0,1,0,0,0,   3, 0, 1,  1, 0, 0, 0, 0);  // re-entry reloads CW only
    add(0, 0,0,0,0,0,   3, 0, 1,  1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)                  // blink phase every 4 ticks
      add(0, 1,0,0,0,0, 3, 0, 1, logic'(((k / BH) % 2) == 0), 0, 0, 0, 0);
    add(0, 1,0,1,0,0,   3, 1, 1,  1, 0, 0, 0, 0);  // edit forces BLINK, tick lost
    add(0, 1,0,0,0,0,   3, 1, 1,  1, 0, 0, 0, 0);
    add(0, 1,0,0,0,0,   3, 1, 1,  1, 0, 0, 0, 0);
    add(0, 1,0,0,0,0,   3, 1, 1,  1, 0, 0, 0, 0);
    add(0, 1,0,0,0,0,   3, 1, 1,  0, 0, 0, 0, 0);
    add(1, 0,0,0,0,0,   0, 0, 0,  1, 0, 0, 0, 0);  // reset mid-operation

    foreach (vecs[k]) begin
      apply(vecs[k].rst, vecs[k].tick, vecs[k].bm, vecs[k].bn, vecs[k].bi, vecs[k].am);
      check($sformatf("vec%0d", k), dut_vec(), vecs[k].exp);
    end

    // ---------------- idle timeout with restart ----------------
    apply(0,0,0,0,0,0);
    apply(0,0,1,0,0,0); apply(0,0,0,0,0,0);
    apply(0,0,1,0,0,0); apply(0,0,0,0,0,0);        // now SET_ALARM, CW1=0
    for (int k = 0; k < 19; k++) begin apply(0,1,0,0,0,0); apply(0,0,0,0,0,0); end
    check("idle_19_ticks", dut_vec(), pk(2, 0, 0, 1, 0, 0, 0, 0) & 12'hEFF | (dut_vec() & 12'h100));
    apply(0,0,0,1,0,0); apply(0,0,0,0,0,0);        // press restarts idle count
    check("press_at_19", dut_vec(), pk(2, 0, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 19; k++) begin apply(0,1,0,0,0,0); apply(0,0,0,0,0,0); end
    check("restart_19_ticks_mode", {10'b0, S}, 12'd2);
    apply(0,1,0,0,0,0);
    check("tick20_mode", {10'b0, S}, 12'd2);
    apply(0,0,0,0,0,0);
    check("timeout_exit", dut_vec(), pk(0, 0, 1, 1, 0, 0, 0, 0));

    // ---------------- reset with btn_next held ----------------
    apply(0,0,1,0,0,0); apply(0,0,0,0,0,0);
    apply(0,0,1,0,0,0); apply(0,0,0,0,0,0);        // SET_ALARM, CW1=0
    apply(0,0,0,1,0,0); apply(0,0,0,0,0,0);        // CW1=1
    apply(0,0,0,1,0,0);                            // CW1=2, held
    check("pre_reset_cw1", dut_vec(), pk(2, 0, 2, 1, 0, 0, 0, 0));
    apply(1,0,0,1,0,0);
    check("reset_held_1", dut_vec(), pk(0, 0, 0, 1, 0, 0, 0, 0));
    apply(1,1,0,1,0,1);
    check("reset_held_2", dut_vec(), pk(0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      apply(0,0,0,1,0,0);
      check($sformatf("post_reset_held%0d", k), dut_vec(), pk(0, 0, 0, 1, 0, 0, 0, 0));
    end
    apply(0,0,0,0,0,0);

    // ---------------- randomized against model ----------------
    apply(1,0,0,0,0,0);
    m_step(1, 0, 0, 0, 0, 0);
    check("rand_reset", dut_vec(), m_exp());
    for (int ph = 0; ph < 3; ph++) begin
      int tog;
      tog = (ph == 0) ? 6 : (ph == 1) ? 40 : 150;
      for (int c = 0; c < 1500; c++) begin
        logic r, t, m, n, i, a;
        r = ($urandom_range(0, 399) == 0);
        t = ($urandom_range(0, 2) == 0);
        m = btn_mode    ^ ($urandom_range(0, tog - 1) == 0);
        n = btn_next    ^ ($urandom_range(0, tog - 1) == 0);
        i = btn_inc     ^ ($urandom_range(0, tog - 1) == 0);
        a = alarm_match ^ ($urandom_range(0, 29) == 0);
        apply(r, t, m, n, i, a);
        m_step(r, t, m, n, i, a);
        check($sformatf("rand_p%0d_c%0d", ph, c), dut_vec(), m_exp());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
